// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy encodings, the
// skid-stage control states and the payload widths of each stage boundary.
package arm_pipe_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // State values double as the occupancy count presented on occ.
  typedef enum logic [1:0] {
    StEmpty = OCC_EMPTY,
    StOne   = OCC_ONE,
    StFull  = OCC_FULL
  } occ_state_e;

  localparam int unsigned IF_ID_W  = 96;   // {instr, pc, pc_plus4}
  localparam int unsigned ID_EX_W  = 160;
  localparam int unsigned EX_MEM_W = 104;
  localparam int unsigned MEM_WB_W = 72;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: valid bit plus payload, with load, clear
// and optional payload clear. Clear has priority over load.
module pipe_slot #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic              clear_data_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      if (clear_data_i) begin
        data_d = RESET_VAL;
      end
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready flow control and a 2-entry skid buffer,
// so in_ready comes from a flop. flush turns the stage into a bubble.
module pipe_stage_skid
  import arm_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                CLR_DATA  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occ
);

  occ_state_e        state_d, state_q;
  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_data, skid_data, main_din;
  logic              main_load, main_clr, main_src_skid;
  logic              skid_load, skid_clr;
  logic              clr_data;
  logic              in_fire, out_fire;

  assign in_ready  = rst & ~skid_v;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_v & out_ready;
  assign out_valid = main_v;
  assign out_data  = main_data;
  assign occ       = state_q;
  assign clr_data  = flush & CLR_DATA;
  assign main_din  = main_src_skid ? skid_data : in_data;

  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_clr      = 1'b0;
    main_src_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clr      = 1'b0;
    if (flush) begin
      // Flush wins over any transfer; a simultaneous in_fire is dropped.
      state_d  = StEmpty;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = StFull;
          end else if (out_fire) begin
            main_clr = 1'b1;
            state_d  = StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            main_load     = 1'b1;
            main_src_skid = 1'b1;
            skid_clr      = 1'b1;
            state_d       = StOne;
          end
        end
        default: begin
          state_d  = StEmpty;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_slot #(
    .DATA_W    (DATA_W),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk_i        (clk),
    .rst_ni       (rst),
    .load_i       (main_load),
    .clear_i      (main_clr),
    .clear_data_i (clr_data),
    .data_i       (main_din),
    .valid_o      (main_v),
    .data_o       (main_data)
  );

  pipe_slot #(
    .DATA_W    (DATA_W),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk_i        (clk),
    .rst_ni       (rst),
    .load_i       (skid_load),
    .clear_i      (skid_clr),
    .clear_data_i (clr_data),
    .data_i       (in_data),
    .valid_o      (skid_v),
    .data_o       (skid_data)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized and directed bench for pipe_stage_skid, checked against a queue-based
// model of the stage; a second instance with CLR_DATA=0 shares all inputs.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 96;
  localparam logic [DW-1:0] RVAL = 96'h0000_00A5_0000_005A_0000_0C3C;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occ;
  logic          nc_in_ready, nc_out_valid;
  logic [DW-1:0] nc_out_data;
  logic [1:0]    nc_occ;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mq[$];
  bit            known;
  logic [DW-1:0] kval;
  bit            nc_known;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .RESET_VAL(RVAL), .CLR_DATA(1'b1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occ       (occ)
  );

  pipe_stage_skid #(.DATA_W(DW), .RESET_VAL(RVAL), .CLR_DATA(1'b0)) u_dut_nc (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (nc_in_ready),
    .out_valid (nc_out_valid),
    .out_data  (nc_out_data),
    .out_ready (out_ready),
    .occ       (nc_occ)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    mq.delete();
    known    = 1'b1;
    kval     = RVAL;
    nc_known = 1'b1;
  endtask

  // Model of one rising edge, using the inputs held across it.
  task automatic model_edge();
    int sz;
    bit inf, outf;
    sz   = mq.size();
    inf  = in_valid && (sz < 2);
    outf = (sz > 0) && out_ready;
    if (flush) begin
      mq.delete();
      known    = 1'b1;
      kval     = RVAL;
      nc_known = 1'b0;
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back(in_data);
      if (outf && mq.size() == 0) begin
        known    = 1'b0;
        nc_known = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    int sz;
    sz = mq.size();
    check("out_valid", DW'(out_valid), DW'(sz > 0));
    check("occ", DW'(occ), DW'(sz));
    check("in_ready", DW'(in_ready), DW'(sz < 2));
    if (sz > 0) check("out_data", out_data, mq[0]);
    else if (known) check("out_data_idle", out_data, kval);
    check("nc_out_valid", DW'(nc_out_valid), DW'(sz > 0));
    check("nc_occ", DW'(nc_occ), DW'(sz));
    check("nc_in_ready", DW'(nc_in_ready), DW'(sz < 2));
    if (sz > 0) check("nc_out_data", nc_out_data, mq[0]);
    else if (nc_known) check("nc_out_data_idle", nc_out_data, RVAL);
  endtask

  task automatic cycle(input bit iv, input logic [DW-1:0] id, input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(32'hDEAD_BEEF);
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_out_valid", DW'(out_valid), '0);
    check("rst_in_ready", DW'(in_ready), '0);
    check("rst_occ", DW'(occ), '0);
    check("rst_out_data", out_data, RVAL);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check_all();

    // Streaming at full throughput.
    for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Stall fills the skid, then drain in order.
    cycle(1'b1, DW'(32'h11), 1'b0, 1'b0);
    cycle(1'b1, DW'(32'h22), 1'b0, 1'b0);
    check("stall_occ", DW'(occ), DW'(2));
    check("stall_in_ready", DW'(in_ready), '0);
    check("stall_head", out_data, DW'(32'h11));
    cycle(1'b1, DW'(32'h99), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("drain_occ", DW'(occ), '0);

    // Flush while FULL with a competing input.
    cycle(1'b1, DW'(32'h44), 1'b0, 1'b0);
    cycle(1'b1, DW'(32'h55), 1'b0, 1'b0);
    cycle(1'b1, DW'(32'h33), 1'b0, 1'b1);
    check("flush_occ", DW'(occ), '0);
    check("flush_data", out_data, RVAL);
    check("flush_nc_hold", nc_out_data, DW'(32'h44));
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges while stalled FULL.
    cycle(1'b1, DW'(32'h66), 1'b0, 1'b0);
    cycle(1'b1, DW'(32'h77), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_out_valid", DW'(out_valid), '0);
    check("async_occ", DW'(occ), '0);
    check("async_in_ready", DW'(in_ready), '0);
    check("async_nc_occ", DW'(nc_occ), '0);
    check("async_out_data", out_data, RVAL);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_all();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 10000; i++) begin
      cycle($urandom_range(0, 99) < 70, rnd96(), $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
